// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the device-side PHY and the host-side transceiver.
//   ps2_state_e : line-protocol FSM states
//   FRAME_BITS  : device-to-host frame length (start, 8 data, parity, stop)
//   RX_BITS     : host-to-device bits clocked in after the start bit
//   odd_parity  : parity bit that makes data plus parity hold an odd count of ones
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned RX_BITS    = 10;

  typedef enum logic [2:0] {
    StIdle,
    StTx,
    StRtsWait,
    StRx,
    StAck
  } ps2_state_e;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one open-collector PS/2 line.
//   clk_i   : system clock
//   reset_i : synchronous active-high reset (line reads released/high)
//   d_i     : asynchronous pad level
//   q_o     : synchronized level
module ps2_line_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ps2_device_phy.sv
// Device-side PS/2 PHY: generates the PS/2 clock, sends 11-bit device frames,
// detects host request-to-send, clocks in host bytes and returns the line ACK.
//   clk, reset            : system clock, synchronous active-high reset
//   wr_ps2, din           : transmit request and byte (taken only when idle)
//   ps2_c_in, ps2_d_in    : pad levels of the PS/2 clock and data lines
//   ps2_c_out, ps2_d_out  : 0 = pull line low, 1 = release
//   dout                  : last received host byte
//   busy                  : frame in progress
//   tx_done, tx_abort     : one-cycle transmit completion / inhibit-abort pulses
//   rx_done, rx_err       : one-cycle receive pulse with parity/stop error flag
module ps2_device_phy
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HALF = 2500,
  parameter int unsigned RTS_MIN  = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2_c_in,
  input  logic       ps2_d_in,
  output logic       ps2_c_out,
  output logic       ps2_d_out,
  output logic [7:0] dout,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       rx_done,
  output logic       rx_err
);

  localparam int unsigned CntMax = (CLK_HALF > RTS_MIN) ? CLK_HALF : RTS_MIN;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] HalfLast  = CntW'(CLK_HALF - 1);
  localparam logic [CntW-1:0] HalfFull  = CntW'(CLK_HALF);
  localparam logic [CntW-1:0] RtsLast   = CntW'(RTS_MIN - 1);
  localparam logic [3:0]      TxLastBit = 4'(FRAME_BITS - 1);
  localparam logic [3:0]      RxLastBit = 4'(RX_BITS - 1);

  logic c_s, d_s;

  ps2_line_sync u_sync_c (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (ps2_c_in),
    .q_o     (c_s)
  );

  ps2_line_sync u_sync_d (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (ps2_d_in),
    .q_o     (d_s)
  );

  ps2_state_e        state_q, state_d;
  // Low-run counter while idle, half-period counter in every other state.
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   hi_run_q, hi_run_d;
  logic [3:0]        bit_q, bit_d;
  // Phase within a bit: TX 0 = clock released, 1 = low; RX/ACK 0 = low, 1 = released.
  logic              ph_q, ph_d;
  logic [10:0]       frame_q, frame_d;
  logic [9:0]        rx_q, rx_d;
  logic              c_out_q, c_out_d;
  logic              d_out_q, d_out_d;
  logic [7:0]        dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_abort_q, tx_abort_d;
  logic              rx_done_q, rx_done_d;
  logic              rx_err_q, rx_err_d;

  logic              half_end;
  logic [3:0]        bit_nxt;

  assign half_end = (cnt_q == HalfLast);
  assign bit_nxt  = bit_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    ph_d       = ph_q;
    frame_d    = frame_q;
    rx_d       = rx_q;
    c_out_d    = c_out_q;
    d_out_d    = d_out_q;
    dout_d     = dout_q;
    tx_done_d  = 1'b0;
    tx_abort_d = 1'b0;
    rx_done_d  = 1'b0;
    rx_err_d   = 1'b0;

    // Saturating count of consecutive synchronized clock-high cycles.
    if (!c_s)                  hi_run_d = '0;
    else if (hi_run_q == HalfFull) hi_run_d = hi_run_q;
    else                       hi_run_d = hi_run_q + CntW'(1);

    unique case (state_q)
      StIdle: begin
        c_out_d = 1'b1;
        d_out_d = 1'b1;
        bit_d   = '0;
        ph_d    = 1'b0;
        cnt_d   = c_s ? '0 : cnt_q + CntW'(1);
        // RTS wins over a same-cycle write; the write is dropped.
        if (!c_s && cnt_q == RtsLast) begin
          state_d = StRtsWait;
          cnt_d   = '0;
        end else if (wr_ps2 && hi_run_q == HalfFull) begin
          state_d = StTx;
          cnt_d   = '0;
          frame_d = {1'b1, odd_parity(din), din, 1'b0};
          d_out_d = 1'b0;
        end
      end

      StTx: begin
        if (half_end) begin
          cnt_d = '0;
          if (!ph_q) begin
            if (!c_s) begin
              // Host is holding the clock low: back off immediately.
              c_out_d    = 1'b1;
              d_out_d    = 1'b1;
              tx_abort_d = 1'b1;
              state_d    = StIdle;
            end else begin
              ph_d    = 1'b1;
              c_out_d = 1'b0;
            end
          end else begin
            ph_d    = 1'b0;
            c_out_d = 1'b1;
            if (bit_q == TxLastBit) begin
              d_out_d   = 1'b1;
              tx_done_d = 1'b1;
              state_d   = StIdle;
            end else begin
              bit_d   = bit_nxt;
              d_out_d = frame_q[bit_nxt];
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StRtsWait: begin
        c_out_d = 1'b1;
        d_out_d = 1'b1;
        if (c_s) begin
          if (!d_s) begin
            state_d = StRx;
            c_out_d = 1'b0;
            cnt_d   = '0;
            ph_d    = 1'b0;
            bit_d   = '0;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end

      StRx: begin
        if (half_end) begin
          cnt_d = '0;
          if (!ph_q) begin
            ph_d    = 1'b1;
            c_out_d = 1'b1;
          end else begin
            rx_d[bit_q] = d_s;
            ph_d        = 1'b0;
            c_out_d     = 1'b0;
            if (bit_q == RxLastBit) begin
              state_d = StAck;
              // Acknowledge only a good stop bit by pulling data low.
              d_out_d = ~d_s;
            end else begin
              bit_d = bit_nxt;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StAck: begin
        if (half_end) begin
          cnt_d = '0;
          if (!ph_q) begin
            ph_d    = 1'b1;
            c_out_d = 1'b1;
          end else begin
            ph_d      = 1'b0;
            d_out_d   = 1'b1;
            dout_d    = rx_q[7:0];
            rx_done_d = 1'b1;
            rx_err_d  = (rx_q[8] != odd_parity(rx_q[7:0])) | ~rx_q[9];
            state_d   = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        c_out_d = 1'b1;
        d_out_d = 1'b1;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_run_q   <= '0;
      bit_q      <= '0;
      ph_q       <= 1'b0;
      frame_q    <= '1;
      rx_q       <= '0;
      c_out_q    <= 1'b1;
      d_out_q    <= 1'b1;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_run_q   <= hi_run_d;
      bit_q      <= bit_d;
      ph_q       <= ph_d;
      frame_q    <= frame_d;
      rx_q       <= rx_d;
      c_out_q    <= c_out_d;
      d_out_q    <= d_out_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      tx_abort_q <= tx_abort_d;
      rx_done_q  <= rx_done_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign ps2_c_out = c_out_q;
  assign ps2_d_out = d_out_q;
  assign dout      = dout_q;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;
  assign tx_abort  = tx_abort_q;
  assign rx_done   = rx_done_q;
  assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_ps2_device_phy.sv
// Directed bench for ps2_device_phy with CLK_HALF=8, RTS_MIN=40; PS/2 lines are
// wired-AND of the DUT outputs and a host model, with implicit pull-ups.
module tb_ps2_device_phy;

  localparam int unsigned Half = 8;
  localparam int unsigned Rts  = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       host_c = 1'b1;
  logic       host_d = 1'b1;
  logic       ps2_c_in, ps2_d_in;
  logic       ps2_c_out, ps2_d_out;
  logic [7:0] dout;
  logic       busy, tx_done, tx_abort, rx_done, rx_err;

  int n_vec = 0;
  int n_err = 0;

  assign ps2_c_in = ps2_c_out & host_c;
  assign ps2_d_in = ps2_d_out & host_d;

  ps2_device_phy #(
    .CLK_HALF (Half),
    .RTS_MIN  (Rts)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_ps2    (wr_ps2),
    .din       (din),
    .ps2_c_in  (ps2_c_in),
    .ps2_d_in  (ps2_d_in),
    .ps2_c_out (ps2_c_out),
    .ps2_d_out (ps2_d_out),
    .dout      (dout),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_abort  (tx_abort),
    .rx_done   (rx_done),
    .rx_err    (rx_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host-to-device transfer: RTS, start bit, 8 data, parity, stop, then ACK.
  // rst_at > 0 pulses reset at that DUT clock fall instead of finishing.
  task automatic host_send(input logic [7:0] d, input logic par, input logic stp,
                           input logic hold_wr, input int rst_at,
                           input logic [7:0] exp_dout, input logic exp_err);
    logic [9:0] bits;
    int         falls;
    logic       prev, viol, done, ack_d, seen;
    bits  = {stp, par, d};
    falls = 0;
    viol  = 1'b0;
    done  = 1'b0;
    seen  = 1'b0;
    ack_d = 1'b1;
    host_c = 1'b0;
    for (int i = 0; i < 4; i++) step();
    wr_ps2 = hold_wr;
    din    = 8'h5A;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ps2_c_out !== 1'b1 || ps2_d_out !== 1'b1) viol = 1'b1;
    end
    wr_ps2 = 1'b0;
    check("rts_lines_released", viol, 0);
    check("rts_busy", busy, 1);
    host_d = 1'b0;
    for (int i = 0; i < 4; i++) step();
    host_c = 1'b1;
    for (int k = 0; k < 400 && !done; k++) begin
      prev = ps2_c_out;
      step();
      if (prev && !ps2_c_out) begin
        falls++;
        if (falls <= 10) begin
          host_d = bits[0];
          bits   = bits >> 1;
        end else begin
          host_d = 1'b1;
          ack_d  = ps2_d_out;
        end
        if (falls == rst_at) begin
          reset = 1'b1;
          step();
          reset  = 1'b0;
          host_d = 1'b1;
          check("rst_c_out", ps2_c_out, 1);
          check("rst_d_out", ps2_d_out, 1);
          check("rst_busy", busy, 0);
          check("rst_dout", dout, 8'h00);
          done = 1'b1;
        end
      end
      if (rx_done) begin
        seen = 1'b1;
        done = 1'b1;
      end
    end
    host_d = 1'b1;
    if (rst_at <= 0) begin
      check("rx_done_seen", seen, 1);
      check("ack_data", ack_d, !stp);
      check("rx_dout", dout, exp_dout);
      check("rx_err", rx_err, exp_err);
      check("rx_busy_low", busy, 0);
    end
  endtask

  initial begin : main
    logic [10:0] exp_bits;
    int          falls, done_k, abort_k, rts_k;
    logic        prev, saw_done;

    // Reset state
    for (int i = 0; i < 3; i++) step();
    check("reset_c_out", ps2_c_out, 1);
    check("reset_d_out", ps2_d_out, 1);
    check("reset_dout", dout, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {tx_done, tx_abort, rx_done, rx_err}, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();

    // TX 0xA5: start 0, data LSB first 1,0,1,0,0,1,0,1, parity 1, stop 1
    exp_bits = 11'b11_1010_0101_0;
    din      = 8'hA5;
    wr_ps2   = 1'b1;
    step();
    wr_ps2 = 1'b0;
    check("tx_busy_rise", busy, 1);
    falls  = 0;
    done_k = 0;
    for (int k = 1; k <= 300 && done_k == 0; k++) begin
      prev = ps2_c_out;
      step();
      if (prev && !ps2_c_out) begin
        case (falls)
          0:  check("tx_bit0",  ps2_d_out, exp_bits[0]);
          1:  check("tx_bit1",  ps2_d_out, exp_bits[1]);
          2:  check("tx_bit2",  ps2_d_out, exp_bits[2]);
          3:  check("tx_bit3",  ps2_d_out, exp_bits[3]);
          4:  check("tx_bit4",  ps2_d_out, exp_bits[4]);
          5:  check("tx_bit5",  ps2_d_out, exp_bits[5]);
          6:  check("tx_bit6",  ps2_d_out, exp_bits[6]);
          7:  check("tx_bit7",  ps2_d_out, exp_bits[7]);
          8:  check("tx_bit8",  ps2_d_out, exp_bits[8]);
          9:  check("tx_parity", ps2_d_out, exp_bits[9]);
          10: check("tx_stop",  ps2_d_out, exp_bits[10]);
          default: check("tx_extra_fall", falls, 10);
        endcase
        falls++;
      end
      if (tx_done) done_k = k;
    end
    check("tx_falls", falls, 11);
    check("tx_done_latency", done_k, 176);
    check("tx_busy_low", busy, 0);
    check("tx_lines_released", {ps2_c_out, ps2_d_out}, 2'b11);
    step();
    check("tx_done_pulse", tx_done, 0);

    // Host RTS then 0xF4, parity 0 (correct), stop 1
    host_send(8'hF4, 1'b0, 1'b1, 1'b0, 0, 8'hF4, 1'b0);
    // Host sends 0xF4 with bad parity
    host_send(8'hF4, 1'b1, 1'b1, 1'b0, 0, 8'hF4, 1'b1);
    for (int i = 0; i < 20; i++) step();

    // Inhibit during bit-4 high phase of a TX
    din    = 8'h3C;
    wr_ps2 = 1'b1;
    step();
    wr_ps2   = 1'b0;
    abort_k  = 0;
    saw_done = 1'b0;
    for (int k = 1; k <= 120 && abort_k == 0; k++) begin
      step();
      if (k == 65) host_c = 1'b0;
      if (tx_done) saw_done = 1'b1;
      if (tx_abort) abort_k = k;
    end
    check("abort_cycle", abort_k, 72);
    check("abort_no_done", saw_done, 0);
    check("abort_lines", {ps2_c_out, ps2_d_out}, 2'b11);
    check("abort_busy", busy, 0);
    step();
    check("abort_pulse", tx_abort, 0);
    rts_k = 1;
    for (int k = 2; k <= 100 && !busy; k++) begin
      step();
      rts_k = k;
    end
    check("abort_rts_after", rts_k, Rts);
    // Release clock with data high: plain inhibit, back to idle with no pulse
    host_c   = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rx_done) saw_done = 1'b1;
    end
    check("inhibit_idle", busy, 0);
    check("inhibit_no_rx", saw_done, 0);

    // wr_ps2 held across the RTS threshold: RX path, no TX bits driven
    host_send(8'h55, 1'b1, 1'b1, 1'b1, 0, 8'h55, 1'b0);

    // Reset pulse during RX bit 5
    host_send(8'hA3, 1'b1, 1'b1, 1'b0, 6, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
